// File: rtl/opposite_counter_array.sv
`default_nettype none
// ============================================================================
//  Module      : opposite_counter_array
//  Description : NUM_CH channels, each holding an explicit value v[i] and an
//                implicit complement imp[i]. Per-channel INC/DEC/LOAD through
//                a valid/ready command port, wrap or saturate arithmetic, and
//                a multi-cycle clear-all walk that resets one channel per
//                cycle. out[i] = v[i] & ~imp[i], which equals v[i] whenever
//                the complement relationship holds.
//                Optional macro OPPOSITE_CNT_CHECK_EN adds a sticky inv_err
//                output and an assertion on imp[i] != ~v[i].
//  Revision    : 1.0  initial release
// ============================================================================
module opposite_counter_array #(
   parameter int WIDTH  = 4,
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2,
   parameter int SAT    = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd_op,
   input  logic [CH_W-1:0]           cmd_ch,
   input  logic [WIDTH-1:0]          cmd_data,
   input  logic                      clr_all,
   output logic [NUM_CH*WIDTH-1:0]   out,
   output logic                      busy,
   output logic                      bad_ch
`ifdef OPPOSITE_CNT_CHECK_EN
   ,
   output logic                      inv_err
`endif
);

   localparam logic [1:0]       C_OP_NOP  = 2'b00;
   localparam logic [1:0]       C_OP_INC  = 2'b01;
   localparam logic [1:0]       C_OP_DEC  = 2'b10;
   localparam logic [1:0]       C_OP_LOAD = 2'b11;
   localparam logic [WIDTH-1:0] C_MAX     = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] C_ZERO    = {WIDTH{1'b0}};

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   state_e            state_q;
   logic [CH_W-1:0]   ptr_q;
   logic [WIDTH-1:0]  v_q   [NUM_CH];
   logic [WIDTH-1:0]  imp_q [NUM_CH];
   logic              bad_ch_q;

   logic              w_accept;
   logic              w_ch_ok;
   logic [WIDTH-1:0]  w_v_cur;
   logic [WIDTH-1:0]  w_imp_cur;
   logic [WIDTH-1:0]  w_v_d;
   logic [WIDTH-1:0]  w_imp_d;

   assign cmd_ready = (state_q == ST_IDLE) & ~clr_all;
   assign busy      = (state_q == ST_CLEAR);
   assign bad_ch    = bad_ch_q;
   assign w_accept  = cmd_valid & cmd_ready;
   assign w_ch_ok   = (32'(cmd_ch) < NUM_CH);

   // Select the addressed channel without indexing past the array end.
   always_comb begin
      w_v_cur   = C_ZERO;
      w_imp_cur = C_MAX;
      for (int i = 0; i < NUM_CH; i++) begin
         if (CH_W'(i) == cmd_ch) begin
            w_v_cur   = v_q[i];
            w_imp_cur = imp_q[i];
         end
      end
   end

   // Next value/complement pair for the addressed channel; both move together,
   // and the complement is advanced from its own register, not derived from v.
   always_comb begin
      w_v_d   = w_v_cur;
      w_imp_d = w_imp_cur;
      case (cmd_op)
         C_OP_INC: begin
            if (!((SAT != 0) && (w_v_cur == C_MAX))) begin
               w_v_d   = w_v_cur + WIDTH'(1);
               w_imp_d = w_imp_cur - WIDTH'(1);
            end
         end
         C_OP_DEC: begin
            if (!((SAT != 0) && (w_v_cur == C_ZERO))) begin
               w_v_d   = w_v_cur - WIDTH'(1);
               w_imp_d = w_imp_cur + WIDTH'(1);
            end
         end
         C_OP_LOAD: begin
            w_v_d   = cmd_data;
            w_imp_d = ~cmd_data;
         end
         C_OP_NOP: begin
            w_v_d   = w_v_cur;
            w_imp_d = w_imp_cur;
         end
         default: begin
            w_v_d   = w_v_cur;
            w_imp_d = w_imp_cur;
         end
      endcase
   end

   // Control FSM plus channel storage: commands in IDLE, one channel cleared per cycle in CLEAR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         bad_ch_q <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            v_q[i]   <= C_ZERO;
            imp_q[i] <= C_MAX;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (clr_all) begin
                  state_q <= ST_CLEAR;
                  ptr_q   <= '0;
               end else if (w_accept) begin
                  if (!w_ch_ok) begin
                     bad_ch_q <= 1'b1;
                  end else begin
                     for (int i = 0; i < NUM_CH; i++) begin
                        if (CH_W'(i) == cmd_ch) begin
                           v_q[i]   <= w_v_d;
                           imp_q[i] <= w_imp_d;
                        end
                     end
                  end
               end
            end
            ST_CLEAR: begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (CH_W'(i) == ptr_q) begin
                     v_q[i]   <= C_ZERO;
                     imp_q[i] <= C_MAX;
                  end
               end
               ptr_q <= ptr_q + CH_W'(1);
               if (32'(ptr_q) == NUM_CH - 1) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_out
         assign out[g*WIDTH +: WIDTH] = v_q[g] & ~imp_q[g];
      end
   endgenerate

`ifdef OPPOSITE_CNT_CHECK_EN
   logic [NUM_CH-1:0] w_mismatch;
   logic              inv_err_q;

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_chk
         assign w_mismatch[g] = (imp_q[g] != ~v_q[g]);
      end
   endgenerate

   // Sticky flag raised the cycle after any channel loses its complement pairing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inv_err_q <= 1'b0;
      end else if (|w_mismatch) begin
         inv_err_q <= 1'b1;
      end
   end

   assign inv_err = inv_err_q;

   a_invariant : assert property (@(posedge clk) disable iff (!rst_n) (w_mismatch == '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_opposite_counter_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_opposite_counter_array
//  Description : Directed, table-driven bench for opposite_counter_array.
//                Instances: default (wrap, 4 ch), SAT=1, and NUM_CH=3.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_opposite_counter_array;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic [1:0]  cmd_op;
   logic [1:0]  cmd_ch;
   logic [3:0]  cmd_data;
   logic        clr_all;

   logic        ready0, busy0, bad0;
   logic [15:0] out0;
   logic        ready_s, busy_s, bad_s;
   logic [15:0] out_s;
   logic        ready3, busy3, bad3;
   logic [11:0] out3;
`ifdef OPPOSITE_CNT_CHECK_EN
   logic        inv0, inv_s, inv3;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   opposite_counter_array #(.WIDTH(4), .NUM_CH(4), .CH_W(2), .SAT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready0),
      .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_data(cmd_data), .clr_all(clr_all),
      .out(out0), .busy(busy0), .bad_ch(bad0)
`ifdef OPPOSITE_CNT_CHECK_EN
      , .inv_err(inv0)
`endif
   );

   opposite_counter_array #(.WIDTH(4), .NUM_CH(4), .CH_W(2), .SAT(1)) dut_sat (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready_s),
      .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_data(cmd_data), .clr_all(clr_all),
      .out(out_s), .busy(busy_s), .bad_ch(bad_s)
`ifdef OPPOSITE_CNT_CHECK_EN
      , .inv_err(inv_s)
`endif
   );

   opposite_counter_array #(.WIDTH(4), .NUM_CH(3), .CH_W(2), .SAT(0)) dut3 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready3),
      .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_data(cmd_data), .clr_all(clr_all),
      .out(out3), .busy(busy3), .bad_ch(bad3)
`ifdef OPPOSITE_CNT_CHECK_EN
      , .inv_err(inv3)
`endif
   );

   localparam logic [1:0] NOP = 2'b00, INC = 2'b01, DEC = 2'b10, LOAD = 2'b11;

   typedef struct {
      logic        valid;
      logic [1:0]  op;
      logic [1:0]  ch;
      logic [3:0]  data;
      logic [15:0] exp_out;
   } vec_t;

   vec_t tv [12];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // One accepted command per call; outputs sampled 1 time unit after the edge.
   task automatic cmd(input logic [1:0] op, input logic [1:0] ch, input logic [3:0] data);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_ch = ch; cmd_data = data;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      tv[0]  = '{1'b1, LOAD, 2'd2, 4'h9, 16'h0900};
      tv[1]  = '{1'b1, LOAD, 2'd1, 4'hF, 16'h09F0};
      tv[2]  = '{1'b1, INC,  2'd1, 4'h0, 16'h0900};
      tv[3]  = '{1'b1, DEC,  2'd1, 4'h0, 16'h09F0};
      tv[4]  = '{1'b1, NOP,  2'd0, 4'h7, 16'h09F0};
      tv[5]  = '{1'b0, INC,  2'd0, 4'h0, 16'h09F0};
      tv[6]  = '{1'b1, INC,  2'd0, 4'h0, 16'h09F1};
      tv[7]  = '{1'b1, DEC,  2'd3, 4'h0, 16'hF9F1};
      tv[8]  = '{1'b1, LOAD, 2'd0, 4'h5, 16'hF9F5};
      tv[9]  = '{1'b1, LOAD, 2'd1, 4'h5, 16'hF955};
      tv[10] = '{1'b1, LOAD, 2'd2, 4'h5, 16'hF555};
      tv[11] = '{1'b1, LOAD, 2'd3, 4'h5, 16'h5555};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = NOP; cmd_ch = 2'd0;
      cmd_data = 4'h0; clr_all = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out",   32'(out0),   32'h0);
      check("rst_busy",  32'(busy0),  32'h0);
      check("rst_bad",   32'(bad0),   32'h0);
      check("rst_ready", 32'(ready0), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;

      // Table: wrap both ways, NOP, unaccepted command, loads of every channel
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         cmd_valid = tv[i].valid; cmd_op = tv[i].op; cmd_ch = tv[i].ch; cmd_data = tv[i].data;
         #1;
         check($sformatf("vec%0d_ready", i), 32'(ready0), 32'h1);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_out", i), 32'(out0), 32'(tv[i].exp_out));
         check($sformatf("vec%0d_busy", i), 32'(busy0), 32'h0);
      end
      check("tbl_bad", 32'(bad0), 32'h0);

      // Clear-all walk with a command held valid throughout
      @(negedge clk);
      clr_all = 1'b1; cmd_valid = 1'b1; cmd_op = INC; cmd_ch = 2'd0;
      #1;
      check("clr_ready_req", 32'(ready0), 32'h0);
      @(posedge clk);
      #1;
      check("clr_enter_busy", 32'(busy0), 32'h1);
      check("clr_enter_out",  32'(out0),  32'h5555);
      @(negedge clk);
      clr_all = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         #1;
         if (k > 1) @(negedge clk);
         check($sformatf("clr%0d_ready_pre", k), 32'(ready0), 32'h0);
         @(posedge clk);
         #1;
         check($sformatf("clr%0d_out", k), 32'(out0), 32'(16'h5555 >> (4 * k)) << (4 * k));
         check($sformatf("clr%0d_busy", k), 32'(busy0), (k < 4) ? 32'h1 : 32'h0);
      end
      check("clr_exit_ready", 32'(ready0), 32'h1);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      check("clr_after_out", 32'(out0), 32'h0);

      // Asynchronous reset during the second cycle of a clear walk
      cmd(LOAD, 2'd3, 4'hA);
      check("rc_load", 32'(out0), 32'hA000);
      @(negedge clk);
      clr_all = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr_all = 1'b0;
      @(posedge clk);
      #1;
      check("rc_busy_before", 32'(busy0), 32'h1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rc_out",   32'(out0),   32'h0);
      check("rc_busy",  32'(busy0),  32'h0);
      check("rc_ready", 32'(ready0), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;

      // Saturating instance next to the wrapping one
      cmd(LOAD, 2'd0, 4'hF);
      check("sat_load", 32'(out_s[3:0]), 32'hF);
      cmd(INC, 2'd0, 4'h0);
      check("sat_inc1", 32'(out_s[3:0]), 32'hF);
      check("wrap_inc", 32'(out0[3:0]),  32'h0);
      cmd(INC, 2'd0, 4'h0);
      check("sat_inc2", 32'(out_s[3:0]), 32'hF);
      cmd(INC, 2'd0, 4'h0);
      check("sat_inc3", 32'(out_s[3:0]), 32'hF);
      cmd(LOAD, 2'd0, 4'h0);
      check("sat_load0", 32'(out_s[3:0]), 32'h0);
      cmd(DEC, 2'd0, 4'h0);
      check("sat_dec",  32'(out_s[3:0]), 32'h0);
      check("wrap_dec", 32'(out0[3:0]),  32'hF);

      // Three-channel instance: out-of-range channel index
      pulse_reset();
      cmd(LOAD, 2'd2, 4'h7);
      check("n3_load", 32'(out3), 32'h700);
      check("n3_bad0", 32'(bad3), 32'h0);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = INC; cmd_ch = 2'd3;
      #1;
      check("n3_ready", 32'(ready3), 32'h1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check("n3_out", 32'(out3), 32'h700);
      check("n3_bad", 32'(bad3), 32'h1);
      repeat (3) @(posedge clk);
      #1;
      check("n3_bad_sticky", 32'(bad3), 32'h1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("n3_bad_rst", 32'(bad3), 32'h0);
      check("n3_out_rst", 32'(out3), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef OPPOSITE_CNT_CHECK_EN
      check("inv_err0", 32'(inv0), 32'h0);
      check("inv_errs", 32'(inv_s), 32'h0);
      check("inv_err3", 32'(inv3), 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
